ifu_fetch_queue: RTL and testbench
==================================

Name: ifu_fetch_queue

Overview:
- Instruction fetch unit that produces the 32-bit instruction words consumed by the decode stage and its immediate generator.
- Holds the fetch PC and issues one instruction-memory read at a time over a valid/ready request channel.
- Queues returned words together with their PCs in a small FIFO.
- Presents the FIFO head to decode over a valid/ready handshake; a redirect from execute flushes everything in flight.

Parameters:
- RESET_PC, 32'h8000_0000, fetch address after reset.
- DEPTH, 2, FIFO entries; power of two, minimum 2.

Ports:
- clk  input  1  sole clock, rising edge.
- rst  input  1  synchronous, active-high reset.
- mem_req_valid  output  1  read request valid.
- mem_req_ready  input  1  memory accepts request.
- mem_req_addr  output  32  word-aligned fetch address.
- mem_rsp_valid  input  1  read data valid; exactly one response per accepted request, no earlier than the cycle after acceptance.
- mem_rsp_data  input  32  instruction word.
- out_valid  output  1  instruction available to decode.
- out_ready  input  1  decode accepts instruction.
- out_inst  output  32  instruction word at FIFO head.
- out_pc  output  32  PC of out_inst.
- redirect_valid  input  1  branch/jump redirect, single-cycle pulse.
- redirect_pc  input  32  new fetch PC; bits [1:0] ignored and forced to 0.

Behaviour:
- Reset (rst high at a clock edge):
  - fetch_pc = RESET_PC, state = REQ, FIFO empty (count 0, pointers 0).
  - out_valid = 0 and mem_req_valid = 0 while rst is high.
  - A reset mid-operation abandons any outstanding request; memory is reset alongside the block.
- FSM states:
  - REQ (may issue a request).
  - WAIT (one request outstanding).
  - DROP (one outstanding response must be discarded).
- REQ:
  - mem_req_valid = (count < DEPTH); mem_req_addr = fetch_pc.
  - On mem_req_valid & mem_req_ready: fetch_pc <= fetch_pc + 4 (32-bit wrap), capture pending_pc = request address, go WAIT.
  - While valid & !ready, valid and addr stay stable, except on a redirect cycle.
- WAIT:
  - mem_req_valid = 0.
  - On mem_rsp_valid: push {pending_pc, mem_rsp_data} into FIFO, go REQ.
  - count never exceeds DEPTH, because a request is issued only with a free slot and the pending response is the only allocation.
- DROP:
  - mem_req_valid = 0.
  - On mem_rsp_valid: discard data, go REQ.
- Output side:
  - out_valid = (count != 0); out_inst/out_pc = head entry.
  - Pop on out_valid & out_ready.
  - Push and pop in the same cycle: count unchanged, both pointers advance (mod DEPTH).
- Redirect (redirect_valid high at edge; highest priority):
  - fetch_pc <= redirect_pc & ~3; FIFO flushed (count 0); out_valid low next cycle.
  - A pop in the redirect cycle is still a legal handshake; the push in that cycle is suppressed.
  - Next state by current state:
    - REQ without handshake: REQ.
    - REQ with handshake this cycle: DROP; fetch_pc takes redirect_pc, not +4.
    - WAIT without mem_rsp_valid: DROP.
    - WAIT with mem_rsp_valid: REQ; response discarded.
    - DROP with mem_rsp_valid: REQ.
    - DROP without mem_rsp_valid: stays DROP.
- Latency and throughput:
  - With mem_req_ready = 1 and a 1-cycle response, the request in cycle N gives a push at the end of N+1 and out_valid in N+2.
  - Sustained rate is 1 instruction per 2 cycles (single outstanding request).
- Ordering: instructions leave in strict fetch order; no PC is skipped or duplicated absent a redirect.

Test Plan:
1. Release reset, mem_req_ready = 1, response 1 cycle after acceptance with data 0x00100093 → req addr 0x80000000 in cycle 0; out_valid in cycle 2 with out_pc 0x80000000, out_inst 0x00100093; next request addr 0x80000004.
2. out_ready = 0 held → FIFO fills (PCs 0x80000000, 0x80000004), mem_req_valid drops and stays 0; raise out_ready → both pop in order, then fetch resumes at 0x80000008.
3. mem_req_ready low for 3 cycles → mem_req_valid high with addr 0x80000000 stable all 3 cycles; accepted on the 4th; fetch_pc advances only after acceptance.
4. Redirect to 0x80000103 while in WAIT → response in the following cycle is dropped; next request addr 0x80000100; no out_valid between flush and the new instruction.
5. Redirect to 0x80000200 in the same cycle as mem_rsp_valid, and separately in the same cycle as a request handshake → first case: no push, next request 0x80000200 without DROP; second case: DROP discards one response, then request 0x80000200.
6. Assert rst for 1 cycle mid-WAIT with 1 FIFO entry valid → out_valid 0, FIFO empty, next request addr 0x80000000.

Source files
------------

// File: rtl/ifu_fetch_queue.sv
// ifu_fetch_queue: instruction fetch unit feeding the decode stage.
//
// Keeps the fetch PC and issues one instruction-memory read at a time. Returned words are
// queued with their PCs in a DEPTH-entry FIFO whose head is presented to decode. A redirect
// from execute flushes the FIFO and discards any response still in flight.
//
// Ports:
//   clk, rst                  clock (rising edge), synchronous active-high reset
//   mem_req_valid/ready/addr  instruction-memory read request channel
//   mem_rsp_valid/data        read response, one per accepted request
//   out_valid/ready/inst/pc   instruction handshake towards decode
//   redirect_valid/pc         single-cycle redirect pulse and its target PC

module ifu_fetch_queue #(
  parameter logic [31:0] RESET_PC = 32'h8000_0000,
  parameter int unsigned DEPTH    = 2
) (
  input  logic        clk,
  input  logic        rst,
  output logic        mem_req_valid,
  input  logic        mem_req_ready,
  output logic [31:0] mem_req_addr,
  input  logic        mem_rsp_valid,
  input  logic [31:0] mem_rsp_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_inst,
  output logic [31:0] out_pc,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc
);

  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam int unsigned CntW = $clog2(DEPTH + 1);
  localparam logic [CntW-1:0] DepthC = CntW'(DEPTH);

  typedef enum logic [1:0] {StReq, StWait, StDrop} state_e;

  state_e          state_q, state_d;
  logic [31:0]     fetch_pc_q, fetch_pc_d;
  logic [31:0]     pending_pc_q, pending_pc_d;
  logic [CntW-1:0] count_q, count_d;
  logic [PtrW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0] rd_ptr_q, rd_ptr_d;

  logic [31:0] inst_mem [DEPTH];
  logic [31:0] pc_mem   [DEPTH];

  logic req_hs;
  logic push;
  logic pop;

  always_comb begin
    mem_req_valid = !rst && (state_q == StReq) && (count_q < DepthC);
    mem_req_addr  = fetch_pc_q;
    out_valid     = !rst && (count_q != '0);
    out_inst      = inst_mem[rd_ptr_q];
    out_pc        = pc_mem[rd_ptr_q];

    req_hs = mem_req_valid && mem_req_ready;
    // A response landing in a redirect cycle belongs to the old path.
    push   = (state_q == StWait) && mem_rsp_valid && !redirect_valid;
    pop    = out_valid && out_ready;
  end

  always_comb begin
    state_d      = state_q;
    fetch_pc_d   = fetch_pc_q;
    pending_pc_d = pending_pc_q;
    count_d      = count_q;
    wr_ptr_d     = wr_ptr_q;
    rd_ptr_d     = rd_ptr_q;

    unique case (state_q)
      StReq: begin
        if (req_hs) begin
          fetch_pc_d   = fetch_pc_q + 32'd4;
          pending_pc_d = fetch_pc_q;
          state_d      = StWait;
        end
      end
      StWait, StDrop: begin
        if (mem_rsp_valid) state_d = StReq;
      end
      default: state_d = StReq;
    endcase

    if (push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
    unique case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase

    if (redirect_valid) begin
      fetch_pc_d = {redirect_pc[31:2], 2'b00};
      count_d    = '0;
      wr_ptr_d   = '0;
      rd_ptr_d   = '0;
      // Any request still owed a response must have that response swallowed in StDrop.
      unique case (state_q)
        StReq:   state_d = req_hs ? StDrop : StReq;
        StWait:  state_d = mem_rsp_valid ? StReq : StDrop;
        StDrop:  state_d = mem_rsp_valid ? StReq : StDrop;
        default: state_d = StReq;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= StReq;
      fetch_pc_q   <= RESET_PC;
      pending_pc_q <= RESET_PC;
      count_q      <= '0;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
    end else begin
      state_q      <= state_d;
      fetch_pc_q   <= fetch_pc_d;
      pending_pc_q <= pending_pc_d;
      count_q      <= count_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
    end
  end

  // Storage needs no reset: entries are only read while count_q says they are valid.
  always_ff @(posedge clk) begin
    if (push && !rst) begin
      inst_mem[wr_ptr_q] <= mem_rsp_data;
      pc_mem[wr_ptr_q]   <= pending_pc_q;
    end
  end

endmodule

// File: tb/tb_ifu_fetch_queue.sv
module tb_ifu_fetch_queue;

  logic        clk = 1'b0;
  logic        rst;
  logic        mem_req_valid;
  logic        mem_req_ready;
  logic [31:0] mem_req_addr;
  logic        mem_rsp_valid;
  logic [31:0] mem_rsp_data;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_inst;
  logic [31:0] out_pc;
  logic        redirect_valid;
  logic [31:0] redirect_pc;

  ifu_fetch_queue #(
    .RESET_PC(32'h8000_0000),
    .DEPTH   (2)
  ) u_dut (
    .clk           (clk),
    .rst           (rst),
    .mem_req_valid (mem_req_valid),
    .mem_req_ready (mem_req_ready),
    .mem_req_addr  (mem_req_addr),
    .mem_rsp_valid (mem_rsp_valid),
    .mem_rsp_data  (mem_rsp_data),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .out_inst      (out_inst),
    .out_pc        (out_pc),
    .redirect_valid(redirect_valid),
    .redirect_pc   (redirect_pc)
  );

  always #5 clk = ~clk;

  int unsigned n_tests = 0;
  int unsigned n_fail  = 0;

  logic [63:0] exp_q [$];      // {pc, inst} expected at decode, in order
  logic [31:0] exp_pc;         // next request address expected
  logic        os;             // memory model: one request outstanding
  int unsigned os_cnt;
  logic [31:0] os_addr;
  int unsigned rsp_delay;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return 32'h0010_0093 + ((a - 32'h8000_0000) << 5);
  endfunction

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %08h expected %08h", tag, got, exp);
    end
  endtask

  // Observe one cycle at the falling edge: scoreboard, request tracking, memory model.
  task automatic sample();
    logic [63:0] e;
    @(negedge clk);
    if (rst) begin
      check_eq("rst_out_valid", {31'd0, out_valid}, 32'd0);
      check_eq("rst_req_valid", {31'd0, mem_req_valid}, 32'd0);
      exp_q.delete();
      exp_pc = 32'h8000_0000;
      os     = 1'b0;
      return;
    end
    if (mem_rsp_valid) os = 1'b0;
    if (out_valid && exp_q.size() == 0) begin
      check_eq("spurious_valid", {31'd0, out_valid}, 32'd0);
    end else if (out_valid && out_ready) begin
      e = exp_q.pop_front();
      check_eq("pop_pc", out_pc, e[63:32]);
      check_eq("pop_inst", out_inst, e[31:0]);
    end
    if (mem_req_valid && mem_req_ready) begin
      check_eq("req_addr", mem_req_addr, exp_pc);
      exp_q.push_back({exp_pc, mem_word(exp_pc)});
      os      = 1'b1;
      os_cnt  = rsp_delay;
      os_addr = mem_req_addr;
      exp_pc  = exp_pc + 32'd4;
    end
    if (redirect_valid) begin
      exp_q.delete();
      exp_pc = {redirect_pc[31:2], 2'b00};
    end
  endtask

  task automatic advance();
    @(posedge clk);
    #1;
    redirect_valid = 1'b0;
    mem_rsp_valid  = 1'b0;
    if (rst) begin
      os = 1'b0;
    end else if (os) begin
      if (os_cnt <= 1) begin
        mem_rsp_valid = 1'b1;
        mem_rsp_data  = mem_word(os_addr);
      end else begin
        os_cnt--;
      end
    end
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) begin
      sample();
      advance();
    end
  endtask

  task automatic do_reset();
    rst            = 1'b1;
    redirect_valid = 1'b0;
    mem_req_ready  = 1'b1;
    out_ready      = 1'b1;
    rsp_delay      = 1;
    sample();
    advance();
    rst = 1'b0;
  endtask

  initial begin
    rst            = 1'b1;
    mem_req_ready  = 1'b0;
    mem_rsp_valid  = 1'b0;
    mem_rsp_data   = '0;
    out_ready      = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = '0;
    rsp_delay      = 1;
    exp_pc         = 32'h8000_0000;
    os             = 1'b0;
    os_cnt         = 0;
    os_addr        = '0;
    run(2);

    // 1: first fetch latency
    do_reset();
    sample();
    check_eq("t1_req_valid", {31'd0, mem_req_valid}, 32'd1);
    check_eq("t1_req_addr", mem_req_addr, 32'h8000_0000);
    advance();
    sample();
    check_eq("t1_c1_out_valid", {31'd0, out_valid}, 32'd0);
    advance();
    sample();
    check_eq("t1_c2_out_valid", {31'd0, out_valid}, 32'd1);
    check_eq("t1_c2_out_pc", out_pc, 32'h8000_0000);
    check_eq("t1_c2_out_inst", out_inst, 32'h0010_0093);
    check_eq("t1_c2_req_addr", mem_req_addr, 32'h8000_0004);
    advance();
    run(6);

    // 2: backpressure fills the FIFO and stalls fetch
    do_reset();
    out_ready = 1'b0;
    run(6);
    for (int i = 0; i < 3; i++) begin
      sample();
      check_eq("t2_full_req_valid", {31'd0, mem_req_valid}, 32'd0);
      check_eq("t2_full_head_pc", out_pc, 32'h8000_0000);
      advance();
    end
    out_ready = 1'b1;
    run(8);

    // 3: request held stable while memory is not ready
    do_reset();
    mem_req_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      sample();
      check_eq("t3_stall_valid", {31'd0, mem_req_valid}, 32'd1);
      check_eq("t3_stall_addr", mem_req_addr, 32'h8000_0000);
      advance();
    end
    mem_req_ready = 1'b1;
    run(6);

    // 4: redirect while waiting for a response
    do_reset();
    rsp_delay = 2;
    run(1);
    redirect_valid = 1'b1;
    redirect_pc    = 32'h8000_0103;
    run(1);
    sample();
    check_eq("t4_drop_req_valid", {31'd0, mem_req_valid}, 32'd0);
    check_eq("t4_drop_out_valid", {31'd0, out_valid}, 32'd0);
    advance();
    sample();
    check_eq("t4_req_valid", {31'd0, mem_req_valid}, 32'd1);
    check_eq("t4_req_addr", mem_req_addr, 32'h8000_0100);
    check_eq("t4_out_valid", {31'd0, out_valid}, 32'd0);
    advance();
    rsp_delay = 1;
    run(8);

    // 5a: redirect coincides with the response
    do_reset();
    run(1);
    redirect_valid = 1'b1;
    redirect_pc    = 32'h8000_0200;
    run(1);
    sample();
    check_eq("t5a_req_valid", {31'd0, mem_req_valid}, 32'd1);
    check_eq("t5a_req_addr", mem_req_addr, 32'h8000_0200);
    check_eq("t5a_out_valid", {31'd0, out_valid}, 32'd0);
    advance();
    run(6);

    // 5b: redirect coincides with a request handshake
    do_reset();
    redirect_valid = 1'b1;
    redirect_pc    = 32'h8000_0200;
    run(1);
    sample();
    check_eq("t5b_drop_req_valid", {31'd0, mem_req_valid}, 32'd0);
    advance();
    sample();
    check_eq("t5b_req_valid", {31'd0, mem_req_valid}, 32'd1);
    check_eq("t5b_req_addr", mem_req_addr, 32'h8000_0200);
    check_eq("t5b_out_valid", {31'd0, out_valid}, 32'd0);
    advance();
    run(6);

    // 6: reset mid-WAIT with one FIFO entry
    do_reset();
    out_ready = 1'b0;
    rsp_delay = 3;
    run(5);
    sample();
    check_eq("t6_pre_out_valid", {31'd0, out_valid}, 32'd1);
    check_eq("t6_pre_req_valid", {31'd0, mem_req_valid}, 32'd0);
    advance();
    rst = 1'b1;
    sample();
    advance();
    rst       = 1'b0;
    rsp_delay = 1;
    sample();
    check_eq("t6_out_valid", {31'd0, out_valid}, 32'd0);
    check_eq("t6_req_valid", {31'd0, mem_req_valid}, 32'd1);
    check_eq("t6_req_addr", mem_req_addr, 32'h8000_0000);
    advance();
    out_ready = 1'b1;
    run(6);

    // Random traffic with occasional redirects
    do_reset();
    for (int i = 0; i < 400; i++) begin
      mem_req_ready = ($urandom_range(0, 3) != 0);
      out_ready     = ($urandom_range(0, 3) != 0);
      rsp_delay     = $urandom_range(1, 3);
      if ($urandom_range(0, 19) == 0) begin
        redirect_valid = 1'b1;
        redirect_pc    = 32'h8000_0000 + $urandom_range(0, 4095);
      end
      sample();
      advance();
    end
    mem_req_ready = 1'b1;
    out_ready     = 1'b1;
    run(12);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
